// File: rtl/mips_mc_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct codes,
// state codes, ALUOp/ALUControl codes and the packed control-word layout.
package mips_mc_control_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MIPS_EXT_INSTR_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_dst;
        logic       iord;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        aluop_t     alu_op;
        logic       ir_write;
        logic       mem_write;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_control_fsm_alu_decoder.sv
// ALU decoder: maps ALUOp (and Funct for R-type) to the 3-bit ALUControl code.
module mips_alu_decoder
    import mips_mc_control_fsm_pkg::*;
(
    input  aluop_t     ALUOp,
    input  logic [5:0] Funct,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALUC_ADD;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (Funct)
                    FN_ADD:  ALUControl = ALUC_ADD;
                    FN_SUB:  ALUControl = ALUC_SUB;
                    FN_AND:  ALUControl = ALUC_AND;
                    FN_OR:   ALUControl = ALUC_OR;
                    FN_SLT:  ALUControl = ALUC_SLT;
                    default: ALUControl = ALUC_ADD;
                endcase
            end
            default: ALUControl = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control_fsm.sv
// Multicycle MIPS control unit: Moore main FSM plus ALU decoder.
// MIPS_EXT_INSTR_EN adds ADDI and J (states ADDIEX, ADDIWB, JUMP).
module mips_mc_control_fsm
    import mips_mc_control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       IorD,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       IllegalOp,
    output logic [3:0] State
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;
    logic   w_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_legal = 1'b0;
        case (Opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ: w_legal = 1'b1;
`ifdef MIPS_EXT_INSTR_EN
            OP_ADDI, OP_J:                  w_legal = 1'b1;
`endif
            default:                        w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: w_next_state = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
`ifdef MIPS_EXT_INSTR_EN
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
`endif
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next_state = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next_state = S_MEMWB;
            S_EXECUTE: w_next_state = S_ALUWB;
`ifdef MIPS_EXT_INSTR_EN
            S_ADDIEX:  w_next_state = S_ADDIWB;
`endif
            default:   w_next_state = S_FETCH;
        endcase
    end

    // Moore decode; unlisted fields stay 0, unreachable codes drive nothing.
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.alu_src_b = 2'b01;
                w_ctrl.ir_write  = 1'b1;
                w_ctrl.pc_write  = 1'b1;
            end
            S_DECODE:  w_ctrl.alu_src_b = 2'b11;
            S_MEMADR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = 2'b10;
            end
            S_MEMRD:   w_ctrl.iord = 1'b1;
            S_MEMWB: begin
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.iord      = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_op    = ALUOP_SUB;
                w_ctrl.pc_src    = 2'b01;
                w_ctrl.branch    = 1'b1;
            end
`ifdef MIPS_EXT_INSTR_EN
            S_ADDIEX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = 2'b10;
            end
            S_ADDIWB:  w_ctrl.reg_write = 1'b1;
            S_JUMP: begin
                w_ctrl.pc_src   = 2'b10;
                w_ctrl.pc_write = 1'b1;
            end
`endif
            default:   w_ctrl = '0;
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .ALUOp      (w_ctrl.alu_op),
        .Funct      (Funct),
        .ALUControl (ALUControl)
    );

    // Reset holds FETCH mux selects but masks every write strobe immediately.
    assign MemToReg  = w_ctrl.mem_to_reg;
    assign RegDst    = w_ctrl.reg_dst;
    assign IorD      = w_ctrl.iord;
    assign PCSrc     = w_ctrl.pc_src;
    assign ALUSrcA   = w_ctrl.alu_src_a;
    assign ALUSrcB   = w_ctrl.alu_src_b;
    assign IRWrite   = w_ctrl.ir_write  & ~reset;
    assign MemWrite  = w_ctrl.mem_write & ~reset;
    assign PCWrite   = w_ctrl.pc_write  & ~reset;
    assign Branch    = w_ctrl.branch    & ~reset;
    assign RegWrite  = w_ctrl.reg_write & ~reset;
    assign PCEn      = (w_ctrl.pc_write | (w_ctrl.branch & Zero)) & ~reset;
    assign IllegalOp = (r_state == S_DECODE) & ~w_legal & ~reset;
    assign State     = r_state;

endmodule
